// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for the multi-digit BCD timer.
// The master drives the strobes and preset; the slave (the timer) drives count and flags.
interface bcd_countdown_timer_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  tick;
  logic                  load;
  logic [4*DIGITS-1:0]   preset;
  logic                  mode_up;
  logic                  hold;
  logic                  abort;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic                  at_end;
  logic                  digit_wrap;

  modport master (
    output tick, load, preset, mode_up, hold, abort,
    input  count, running, done, at_end, digit_wrap
  );

  modport slave (
    input  tick, load, preset, mode_up, hold, abort,
    output count, running, done, at_end, digit_wrap
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD up/down timer with preset load, hold and terminal detection.
// Counting advances only on the tick enable; all outputs come straight from registers.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned TOP_MAX = 5
) (
  input  logic                 clk,
  input  logic                 clear_n,
  bcd_countdown_timer_if.slave bus
);

  localparam int unsigned W      = 4 * DIGITS;
  localparam int          Top    = DIGITS - 1;
  localparam logic [3:0]  TopMax = 4'(TOP_MAX);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] target_q, target_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic         wrap_q, wrap_d;

  logic [W-1:0] preset_sat;
  logic [W-1:0] count_inc;
  logic [W-1:0] count_dec;
  logic [W-1:0] count_step;
  logic [W-1:0] terminal;

  // Clamp out-of-range digits so the target is always reachable from either end.
  always_comb begin
    preset_sat = bus.preset;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == Top) begin
        if (bus.preset[4*i+:4] > TopMax) preset_sat[4*i+:4] = TopMax;
      end else if (bus.preset[4*i+:4] > 4'd9) begin
        preset_sat[4*i+:4] = 4'd9;
      end
    end
  end

  // Ripple carry/borrow; the top digit never wraps since the terminal value stops the count.
  always_comb begin
    logic carry;
    logic borrow;
    carry     = 1'b1;
    borrow    = 1'b1;
    count_inc = count_q;
    count_dec = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (i != Top && count_q[4*i+:4] == 4'd9) begin
          count_inc[4*i+:4] = 4'd0;
        end else begin
          count_inc[4*i+:4] = count_q[4*i+:4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i+:4] == 4'd0) begin
          count_dec[4*i+:4] = 4'd9;
        end else begin
          count_dec[4*i+:4] = count_q[4*i+:4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign count_step = mode_q ? count_inc : count_dec;
  assign terminal   = mode_q ? target_q : '0;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
      count_d = '0;
    end else if (bus.load) begin
      target_d = preset_sat;
      mode_d   = bus.mode_up;
      count_d  = bus.mode_up ? '0 : preset_sat;
      // Start and terminal coincide only for a zero target, in either direction.
      if (preset_sat == '0) begin
        state_d = StDone;
        done_d  = 1'b1;
      end else begin
        state_d = StRun;
      end
    end else begin
      case (state_q)
        StRun: begin
          if (bus.hold) begin
            state_d = StHold;
          end else if (bus.tick) begin
            count_d = count_step;
            wrap_d  = mode_q ? (count_q[3:0] == 4'd9) : (count_q[3:0] == 4'd0);
            if (count_step == terminal) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StHold: begin
          if (!bus.hold) state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      target_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.running    = (state_q == StRun);
  assign bus.at_end     = (state_q == StDone);
  assign bus.done       = done_q;
  assign bus.digit_wrap = wrap_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (2 digits, top digit max 5).
// Expected outputs are queued as each cycle's stimulus is driven and checked after the edge.
module tb_bcd_countdown_timer;

  localparam int unsigned DIGITS  = 2;
  localparam int unsigned TOP_MAX = 5;

  typedef struct packed {
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       at_end;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic clear_n;

  exp_t        sb_q[$];
  string       tag_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_countdown_timer #(
    .DIGITS (DIGITS),
    .TOP_MAX(TOP_MAX)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .bus    (bus)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] b;
    b[7:4] = 4'(v / 10);
    b[3:0] = 4'(v % 10);
    return b;
  endfunction

  function automatic exp_t mk(input logic [7:0] c, input logic r, input logic d,
                              input logic a, input logic w);
    exp_t e;
    e.count   = c;
    e.running = r;
    e.done    = d;
    e.at_end  = a;
    e.wrap    = w;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic score();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".count"},   bus.count,           e.count);
    check_eq({t, ".running"}, 8'(bus.running),     8'(e.running));
    check_eq({t, ".done"},    8'(bus.done),        8'(e.done));
    check_eq({t, ".at_end"},  8'(bus.at_end),      8'(e.at_end));
    check_eq({t, ".wrap"},    8'(bus.digit_wrap),  8'(e.wrap));
  endtask

  task automatic expect_now(input string tag, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    score();
  endtask

  // One clock of stimulus; result is checked just after the following rising edge.
  task automatic cycle(input string tag, input logic t, input logic ld, input logic h,
                       input logic ab, input logic [7:0] pre, input logic up, input exp_t e);
    @(negedge clk);
    bus.tick    = t;
    bus.load    = ld;
    bus.hold    = h;
    bus.abort   = ab;
    bus.preset  = pre;
    bus.mode_up = up;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    score();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    clear_n     = 1'b0;
    bus.tick    = 1'b0;
    bus.load    = 1'b0;
    bus.hold    = 1'b0;
    bus.abort   = 1'b0;
    bus.preset  = 8'h00;
    bus.mode_up = 1'b0;
    #12;
    expect_now("reset", mk(8'h00, 0, 0, 0, 0));
    @(negedge clk);
    clear_n = 1'b1;

    cycle("idle_tick", 1, 0, 0, 0, 8'h00, 0, mk(8'h00, 0, 0, 0, 0));

    // Down from 12; coincident tick on load is ignored.
    cycle("load12", 1, 1, 0, 0, 8'h12, 0, mk(8'h12, 1, 0, 0, 0));
    for (int k = 11; k >= 0; k--) begin
      cycle($sformatf("down%0d", k), 1, 0, 0, 0, 8'h00, 0,
            mk(to_bcd(k), k != 0, k == 0, k == 0, k == 9));
    end
    cycle("tick_after_done", 1, 0, 0, 0, 8'h00, 0, mk(8'h00, 0, 0, 1, 0));
    cycle("done_idle",       0, 0, 0, 0, 8'h00, 0, mk(8'h00, 0, 0, 1, 0));

    // Invalid preset 7A saturates to 59; count up.
    cycle("load7A_up", 0, 1, 0, 0, 8'h7A, 1, mk(8'h00, 1, 0, 0, 0));
    for (int k = 1; k <= 59; k++) begin
      cycle($sformatf("up%0d", k), 1, 0, 0, 0, 8'h00, 0,
            mk(to_bcd(k), k != 59, k == 59, k == 59, (k % 10) == 0));
    end

    // Hold at 05: tick on the hold edge is discarded, release tick is ignored.
    cycle("load08", 0, 1, 0, 0, 8'h08, 0, mk(8'h08, 1, 0, 0, 0));
    for (int k = 7; k >= 5; k--) begin
      cycle($sformatf("pre_hold%0d", k), 1, 0, 0, 0, 8'h00, 0, mk(to_bcd(k), 1, 0, 0, 0));
    end
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("hold%0d", k), 1, 0, 1, 0, 8'h00, 0, mk(8'h05, 0, 0, 0, 0));
    end
    cycle("release", 1, 0, 0, 0, 8'h00, 0, mk(8'h05, 1, 0, 0, 0));
    cycle("after_hold", 1, 0, 0, 0, 8'h00, 0, mk(8'h04, 1, 0, 0, 0));

    // Zero preset goes straight to DONE.
    cycle("load00", 0, 1, 0, 0, 8'h00, 0, mk(8'h00, 0, 1, 1, 0));
    cycle("done_ignores", 1, 0, 1, 0, 8'h00, 0, mk(8'h00, 0, 0, 1, 0));

    // Load from DONE restarts.
    cycle("reload03", 1, 1, 0, 0, 8'h03, 0, mk(8'h03, 1, 0, 0, 0));
    cycle("reload_step", 1, 0, 0, 0, 8'h00, 0, mk(8'h02, 1, 0, 0, 0));

    // abort beats load.
    cycle("abort_load", 1, 1, 0, 1, 8'h30, 0, mk(8'h00, 0, 0, 0, 0));
    cycle("after_abort", 1, 0, 0, 0, 8'h00, 0, mk(8'h00, 0, 0, 0, 0));

    // Async reset mid-run at 37, checked between clock edges.
    cycle("load37", 0, 1, 0, 0, 8'h37, 0, mk(8'h37, 1, 0, 0, 0));
    bus.load = 1'b0;
    #3;
    clear_n = 1'b0;
    #1;
    expect_now("async_reset", mk(8'h00, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD timer for the fill/clean irrigation sequencing path.
- Generalises the single-digit seconds counter:
  - N digits, top digit with a configurable modulus, so 2 digits default to 00–59.
  - Preset load.
  - Down mode (preset→0) or up mode (0→preset).
  - Hold/pause input.
  - Explicit state machine and terminal flag.
- Fully synchronous on one clock; counting is advanced by a 1 Hz tick enable, never by a gated clock.

Parameters:
- DIGITS, 2, number of BCD digits (1..6); digit 0 is least significant.
- TOP_MAX, 5, maximum value of the most significant digit (1..9); all other digits max 9.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle count-enable strobe (1 Hz in system).
- load  in  1  capture preset and mode; start timing.
- preset  in  4*DIGITS  BCD preset/target value.
- mode_up  in  1  0 = count down preset→0, 1 = count up 0→preset; sampled only on load.
- hold  in  1  pause request (sensor inhibit / level alarm).
- abort  in  1  stop and clear to IDLE.
- count  out  4*DIGITS  current BCD value.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse on reaching terminal value.
- at_end  out  1  level, high in DONE state.
- digit_wrap  out  1  one-cycle pulse when digit 0 wraps (9→0 up, 0→9 down); used for cascading.

Behaviour:
- Reset (clear_n=0, async):
  - state=IDLE, count=0, stored mode=0, stored target=0.
  - running=0, done=0, at_end=0, digit_wrap=0.
- Preset sanitising on load: any digit >9 is saturated to 9; top digit >TOP_MAX is saturated to TOP_MAX.
- States: IDLE, RUN, HOLD, DONE. Event priority per edge: abort > load > hold > tick.
- abort (any state): next state IDLE, count=0; done not pulsed.
- load (any state except abort same cycle):
  - Store mode_up and sanitised preset as target.
  - count = target if down, 0 if up.
  - If count equals terminal (0 for down, target for up), go directly to DONE with done=1 next cycle.
  - Otherwise go to RUN. A tick coincident with load is ignored.
- RUN:
  - hold=1 → HOLD; a coincident tick is discarded.
  - tick=1 and hold=0 → step count by 1 in BCD with ripple borrow/carry across digits.
  - Each step is registered; count updates the cycle after the tick edge (latency 1).
  - If the new value equals terminal → DONE and done=1 for exactly that cycle.
- HOLD:
  - count frozen; ticks ignored; running=0.
  - hold=0 → RUN; the first tick is accepted on the cycle after returning to RUN.
- DONE: count frozen at terminal; at_end=1; ticks and hold ignored; leaves only via load or abort.
- BCD arithmetic:
  - Down: digit 0 at 0 becomes 9 and borrows into the next digit. The top digit never underflows, because terminal 0 stops the count.
  - Up: digit 9 becomes 0 and carries. The top digit never exceeds TOP_MAX, because target ≤ max.
- digit_wrap: registered, asserted the same cycle count shows the wrapped digit 0; never asserted outside RUN steps.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-RUN with count=37:
  - Assert clear_n=0 → count=00, state IDLE, all flags 0 without waiting for a clk edge.
- DIGITS=2, load preset=0x12, down, then 12 ticks:
  - count sequence 12,11,10,09,…,00.
  - digit_wrap pulses once at 10→09.
  - done pulses exactly once with 00.
  - at_end=1 afterwards; a 13th tick leaves count 00.
- Load preset=0x7A (invalid):
  - Target saturates to 0x59.
  - Up mode counts 00→59 in 59 ticks; done on 59.
- Hold during RUN at count=05:
  - hold=1 for 3 ticks → count stays 05, running=0.
  - Release, then next tick → 04.
  - A tick on the same edge as hold rising is discarded.
- Load with preset=00 in down mode → DONE next cycle, done=1 one cycle, running never 1.
- Same-edge conflicts:
  - abort+load → IDLE, count 00.
  - load+tick → count equals preset (no step).
  - load during DONE restarts timing with the new preset.
